shifter: RTL and testbench
==========================

SHIFTER -- requirements
Module: shifter

Interface
REQ-001 Parameter: WIDTH, default 16, datapath width in bits; all requirements use WIDTH=16 unless stated.
REQ-002 Port: clk  input  1  single rising-edge clock for all registered outputs.
REQ-003 Port: reset  input  1  synchronous, active-high reset; sampled only on the rising edge of clk.
REQ-004 Port: in  input  WIDTH  operand to be shifted.
REQ-005 Port: shift  input  2  operation select: 00 pass, 01 logical left by 1, 10 logical right by 1, 11 arithmetic right by 1.
REQ-006 Port: en  input  1  register-load enable for the registered outputs.
REQ-007 Port: sout  output  WIDTH  combinational shift result.
REQ-008 Port: sout_q  output  WIDTH  registered copy of sout.
REQ-009 Port: cout_q  output  1  registered bit shifted out of the operand.
REQ-010 Port: z_q  output  1  registered flag, set when the result is all zeros.
REQ-011 Port: n_q  output  1  registered flag, equal to the result MSB.

Function
REQ-012 sout SHALL be purely combinational from in and shift, with zero clock latency and no dependence on clk, reset or en.
REQ-013 shift=00: sout SHALL equal in.
REQ-014 shift=01: sout SHALL equal {in[WIDTH-2:0],1'b0}; LSB filled with 0, in[WIDTH-1] discarded.
REQ-015 shift=10: sout SHALL equal {1'b0,in[WIDTH-1:1]}; MSB filled with 0, in[0] discarded.
REQ-016 shift=11: sout SHALL equal {in[WIDTH-1],in[WIDTH-1:1]}; MSB replicated (sign extension).
REQ-017 The shift-out bit SHALL be 0 for shift=00, in[WIDTH-1] for shift=01, and in[0] for shift=10 or 11.
REQ-018 When en=1 and reset=0, each rising clk edge SHALL load sout_q<=sout, cout_q<=shift-out bit, z_q<=(sout==0), and n_q<=sout[WIDTH-1].
REQ-019 When en=0 and reset=0, all registered outputs SHALL hold their values.
REQ-020 Registered outputs SHALL appear one clk edge after the inputs are sampled (latency 1).
REQ-021 Unknown or X values on shift SHALL NOT be decoded to a legal operation in simulation; the resulting sout is don't-care.
REQ-022 The design SHALL contain no latches; the combinational path SHALL be fully specified for all four shift codes.

Reset
REQ-023 When reset=1 at a rising clk edge, sout_q, cout_q, z_q and n_q SHALL become 0, regardless of en.
REQ-024 Reset has priority over en.
REQ-025 A reset asserted in the middle of a stream of loads SHALL discard the pending load on that edge.
REQ-026 Reset SHALL NOT affect the combinational sout output.

Verification
REQ-027 in=16'h000F, shift=00 -> sout=16'h000F; after a clk edge with en=1: cout_q=0, z_q=0, n_q=0.
REQ-028 in=16'h000F, shift=01 -> sout=16'h001E; cout_q=0.
REQ-029 in=16'h000F, shift=10 -> sout=16'h0007; cout_q=1.
REQ-030 in=16'h800E, shift=11 -> sout=16'hC007; after a clk edge with en=1: n_q=1, cout_q=0.
REQ-031 in=16'h0001, shift=10, en=1 -> sout=0 and z_q=1, cout_q=1; next edge with en=0 and new input values -> all registered outputs unchanged.
REQ-032 Load a nonzero result, then assert reset=1 with en=1 -> all registered outputs 0 after the edge while sout still tracks in and shift.

Source files
------------

// File: rtl/shifter.sv
// Single-bit shifter (pass / lsl / lsr / asr) with a combinational result and
// a registered copy plus carry-out, zero and negative flags.
module shifter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       shift,
    input  logic             en,
    output logic [WIDTH-1:0] sout,
    output logic [WIDTH-1:0] sout_q,
    output logic             cout_q,
    output logic             z_q,
    output logic             n_q
);

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             cout;
        logic             z;
        logic             n;
    } flags_t;

    logic   cout;
    flags_t nxt;
    flags_t cur;

    // An X select falls to the default arm so it never aliases a legal op.
    always_comb begin
        sout = in;
        cout = 1'b0;
        case (shift)
            2'b00: begin sout = in;                          cout = 1'b0;         end
            2'b01: begin sout = {in[WIDTH-2:0], 1'b0};       cout = in[WIDTH-1];  end
            2'b10: begin sout = {1'b0, in[WIDTH-1:1]};       cout = in[0];        end
            2'b11: begin sout = {in[WIDTH-1], in[WIDTH-1:1]}; cout = in[0];       end
            default: begin sout = 'x;                        cout = 1'bx;         end
        endcase
    end

    always_comb begin
        nxt      = cur;
        nxt.res  = sout;
        nxt.cout = cout;
        nxt.z    = (sout == '0);
        nxt.n    = sout[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (reset)   cur <= '0;
        else if (en) cur <= nxt;
    end

    assign sout_q = cur.res;
    assign cout_q = cur.cout;
    assign z_q    = cur.z;
    assign n_q    = cur.n;

endmodule

// File: tb/tb_shifter.sv
// Scoreboarded bench for shifter: expected registered state is queued when
// stimulus is driven and compared one edge later.
module tb_shifter;

    localparam int WIDTH = 16;

    typedef struct packed {
        logic [WIDTH-1:0] sout_q;
        logic             cout_q;
        logic             z_q;
        logic             n_q;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] in;
    logic [1:0]       shift;
    logic             en;
    logic [WIDTH-1:0] sout;
    logic [WIDTH-1:0] sout_q;
    logic             cout_q, z_q, n_q;

    shifter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .in(in), .shift(shift), .en(en),
        .sout(sout), .sout_q(sout_q), .cout_q(cout_q), .z_q(z_q), .n_q(n_q)
    );

    always #5 clk = ~clk;

    int   n_chk  = 0;
    int   n_pass = 0;
    exp_t sb_q[$];
    exp_t model;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [WIDTH-1:0] ref_res(input logic [WIDTH-1:0] a, input logic [1:0] s);
        case (s)
            2'b01:   return a << 1;
            2'b10:   return a >> 1;
            2'b11:   return WIDTH'($signed(a) >>> 1);
            default: return a;
        endcase
    endfunction

    function automatic logic ref_cout(input logic [WIDTH-1:0] a, input logic [1:0] s);
        if (s == 2'b00) return 1'b0;
        if (s == 2'b01) return a[WIDTH-1];
        return a[0];
    endfunction

    // Drive one cycle, check sout combinationally, queue the registered expectation,
    // then pop and compare after the edge.
    task automatic step(input logic [WIDTH-1:0] a, input logic [1:0] s, input logic e, input logic r);
        exp_t nx, got;
        logic [WIDTH-1:0] res;
        @(negedge clk);
        in = a; shift = s; en = e; reset = r;
        #1;
        res = ref_res(a, s);
        chk("sout", 32'(sout), 32'(res));
        if (r)      nx = '0;
        else if (e) nx = '{res, ref_cout(a, s), (res == '0), res[WIDTH-1]};
        else        nx = model;
        model = nx;
        sb_q.push_back(nx);
        @(posedge clk);
        #1;
        chk("sout_post", 32'(sout), 32'(res));
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 32'd0, 32'd1);
        end else begin
            got = sb_q.pop_front();
            chk("sout_q", 32'(sout_q), 32'(got.sout_q));
            chk("cout_q", 32'(cout_q), 32'(got.cout_q));
            chk("z_q",    32'(z_q),    32'(got.z_q));
            chk("n_q",    32'(n_q),    32'(got.n_q));
        end
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; in = '0; shift = 2'b00;
        model = '0;
        // Reset state, with en low and then high
        step(16'hFFFF, 2'b01, 1'b0, 1'b1);
        step(16'hFFFF, 2'b01, 1'b1, 1'b1);
        // Directed vectors
        step(16'h000F, 2'b00, 1'b1, 1'b0);
        chk("v27_sout", 32'(sout_q), 32'h000F);
        step(16'h000F, 2'b01, 1'b1, 1'b0);
        chk("v28_sout", 32'(sout_q), 32'h001E);
        step(16'h000F, 2'b10, 1'b1, 1'b0);
        chk("v29_cout", 32'(cout_q), 32'd1);
        step(16'h800E, 2'b11, 1'b1, 1'b0);
        chk("v30_sout", 32'(sout_q), 32'hC007);
        chk("v30_n",    32'(n_q),    32'd1);
        step(16'h0001, 2'b10, 1'b1, 1'b0);
        chk("v31_z",    32'(z_q),    32'd1);
        // Hold with en low and new inputs
        step(16'hA5A5, 2'b01, 1'b0, 1'b0);
        chk("v31_hold", 32'(z_q),    32'd1);
        step(16'h8001, 2'b01, 1'b1, 1'b0);
        // Reset mid-stream with en high discards the load
        step(16'h1234, 2'b00, 1'b1, 1'b1);
        chk("v32_rst",  32'(sout_q), 32'd0);
        step(16'hFFFF, 2'b11, 1'b1, 1'b0);
        // Random stream
        for (int i = 0; i < 60; i++)
            step(WIDTH'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
